// File: rtl/bus_arb_mux.sv
// bus_arb_mux: arbitrated NUM_SRC:1 bus mux feeding a registered valid/ready output slice
module bus_arb_mux #(
  parameter int WIDTH = 32,
  parameter int NUM_SRC = 4,
  parameter int ARB_MODE = 0,
  localparam int SRC_W = $clog2(NUM_SRC)
) (
  input  logic                     clk,
  input  logic                     clr_n,
  input  logic [NUM_SRC-1:0]       req,
  input  logic [NUM_SRC*WIDTH-1:0] data_in,
  output logic [NUM_SRC-1:0]       grant,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [SRC_W-1:0]         out_src
);
  localparam logic [SRC_W-1:0] LAST = SRC_W'(NUM_SRC - 1);
  logic [SRC_W-1:0] rr_ptr, base, win;
  logic load;
  assign base = (ARB_MODE != 0) ? '0 : rr_ptr;
  assign load = clr_n & (|req) & (~out_valid | out_ready);
  assign grant = load ? (NUM_SRC'(1) << win) : '0;
  // descending scan so the first requester at or after base is the last one written
  always_comb begin
    win = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--)
      if (req[(int'(base) + k) % NUM_SRC]) win = SRC_W'((int'(base) + k) % NUM_SRC);
  end
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_src <= '0;
      rr_ptr <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data <= data_in[int'(win)*WIDTH +: WIDTH];
      out_src <= win;
      if (ARB_MODE == 0) rr_ptr <= (win == LAST) ? '0 : win + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_bus_arb_mux.sv
// tb_bus_arb_mux: directed scoreboard bench for round-robin (4 and 3 sources) and fixed-priority instances
module tb_bus_arb_mux;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic clr_n = 1'b0;
  logic [127:0] din = '0;
  logic [3:0] req_v [3];
  logic rdy_v [3];
  logic [3:0] gv [3];
  logic ov [3];
  logic [31:0] od [3];
  logic [1:0] os [3];
  logic [2:0] g_c;
  int checks = 0, errors = 0;
  int mptr [3];
  logic mv [3];
  logic [33:0] lw [3];
  logic [33:0] sb [$];

  bus_arb_mux #(.WIDTH(32), .NUM_SRC(4), .ARB_MODE(0)) u_rr4 (
    .clk(clk), .clr_n(clr_n), .req(req_v[0]), .data_in(din), .grant(gv[0]),
    .out_valid(ov[0]), .out_ready(rdy_v[0]), .out_data(od[0]), .out_src(os[0]));
  bus_arb_mux #(.WIDTH(32), .NUM_SRC(4), .ARB_MODE(1)) u_fp4 (
    .clk(clk), .clr_n(clr_n), .req(req_v[1]), .data_in(din), .grant(gv[1]),
    .out_valid(ov[1]), .out_ready(rdy_v[1]), .out_data(od[1]), .out_src(os[1]));
  bus_arb_mux #(.WIDTH(32), .NUM_SRC(3), .ARB_MODE(0)) u_rr3 (
    .clk(clk), .clr_n(clr_n), .req(req_v[2][2:0]), .data_in(din[95:0]), .grant(g_c),
    .out_valid(ov[2]), .out_ready(rdy_v[2]), .out_data(od[2]), .out_src(os[2]));
  assign gv[2] = {1'b0, g_c};

  function automatic int pick(logic [3:0] r, int n, int p);
    for (int k = 0; k < n; k++) if (r[(p + k) % n]) return (p + k) % n;
    return -1;
  endfunction

  task automatic chk(string tag, logic [63:0] o, logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  // one clock of stimulus on instance u; unrequested slices carry X
  task automatic cyc(int u, logic [3:0] r, logic rdy, logic [31:0] b);
    int n, w;
    logic ld;
    n = (u == 2) ? 3 : 4;
    for (int i = 0; i < 4; i++) din[i*32 +: 32] = r[i] ? b + 32'(i) + 32'd1 : 'x;
    req_v[u] = r;
    rdy_v[u] = rdy;
    #1;
    w = pick(r, n, mptr[u]);
    ld = clr_n && w >= 0 && (!mv[u] || rdy);
    chk($sformatf("grant[%0d]", u), 64'(gv[u]), ld ? (64'd1 << w) : 64'd0);
    if (!clr_n) begin
      for (int v = 0; v < 3; v++) begin
        mv[v] = 1'b0;
        mptr[v] = 0;
        lw[v] = '0;
      end
    end else if (ld) begin
      sb.push_back({2'(w), din[w*32 +: 32]});
      mv[u] = 1'b1;
      if (u != 1) mptr[u] = (w + 1) % n;
    end else if (rdy) mv[u] = 1'b0;
    @(posedge clk);
    #1;
    chk($sformatf("out_valid[%0d]", u), 64'(ov[u]), 64'(mv[u]));
    if (ld) lw[u] = sb.pop_front();
    if (mv[u] || !clr_n) begin
      chk($sformatf("out_src[%0d]", u), 64'(os[u]), 64'(lw[u][33:32]));
      chk($sformatf("out_data[%0d]", u), 64'(od[u]), 64'(lw[u][31:0]));
    end
  endtask

  initial begin
    for (int v = 0; v < 3; v++) begin
      req_v[v] = '0;
      rdy_v[v] = 1'b1;
      mptr[v] = 0;
      mv[v] = 1'b0;
      lw[v] = '0;
    end
    clr_n = 1'b0;
    repeat (2) cyc(0, 4'b1111, 1'b1, $urandom);
    clr_n = 1'b1;
    repeat (5) cyc(0, 4'b1111, 1'b1, $urandom);
    cyc(0, 4'b0001, 1'b1, 32'hA5A5_0000);
    repeat (5) cyc(0, 4'b0110, 1'b0, $urandom);
    cyc(0, 4'b0110, 1'b1, $urandom);
    repeat (2) cyc(0, 4'b0000, 1'b1, $urandom);
    cyc(0, 4'b0010, 1'b1, $urandom);
    cyc(0, 4'b0100, 1'b0, $urandom);
    clr_n = 1'b0;
    cyc(0, 4'b0100, 1'b0, $urandom);
    clr_n = 1'b1;
    cyc(0, 4'b1010, 1'b1, $urandom);
    cyc(0, 4'b0000, 1'b1, $urandom);
    clr_n = 1'b0;
    cyc(1, 4'b0000, 1'b1, $urandom);
    clr_n = 1'b1;
    repeat (4) cyc(1, 4'b1010, 1'b1, $urandom);
    cyc(1, 4'b1010, 1'b0, $urandom);
    cyc(1, 4'b1000, 1'b1, $urandom);
    cyc(1, 4'b0000, 1'b1, $urandom);
    clr_n = 1'b0;
    cyc(2, 4'b0111, 1'b1, $urandom);
    clr_n = 1'b1;
    cyc(2, 4'b0010, 1'b1, $urandom);
    cyc(2, 4'b0011, 1'b1, $urandom);
    repeat (4) cyc(2, 4'b0111, 1'b1, $urandom);
    cyc(2, 4'b0100, 1'b1, $urandom);
    cyc(2, 4'b0101, 1'b1, $urandom);
    cyc(2, 4'b0000, 1'b1, $urandom);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
